uart_rx_param: RTL and testbench

//  Parametrised UART receiver; successor to the fixed 8-bit receiver with its separate start/SIPO/parity/stop units.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx_param.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Holds the receive FSM state encoding, the parity-mode constants and a constant log2 helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    // Ceiling log2, used to size counters and FIFO pointers at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received frames as {parity_err, stop_err, data}.
// Pointers carry one extra MSB so full and empty can be told apart.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with glitch-start rejection, optional parity,
// 1-2 stop bits and an output FIFO drained through a valid/ready handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 rx_inp,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 overrun
);

    localparam int CW     = clog2(OVERSAMPLE);
    localparam int BW     = clog2(DATA_BITS + 1);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

    rx_state_t            state, state_n;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 perr, perr_n;
    logic                 serr, serr_n;
    logic                 need_high, need_high_n;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WORD_W-1:0]    head;

    // Synchroniser presets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_inp;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            serr      <= 1'b0;
            need_high <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            perr      <= perr_n;
            serr      <= serr_n;
            need_high <= need_high_n;
        end
    end

    // need_high blocks a new start after a frame whose last stop sample was low (line break).
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_n       = bit_cnt;
        shift_n     = shift;
        perr_n      = perr;
        serr_n      = serr;
        need_high_n = need_high && !rxs;
        push        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs && !need_high) begin
                    state_n = ST_START;
                    cnt_n   = '0;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    perr_n  = 1'b0;
                    serr_n  = 1'b0;
                    state_n = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rxs, shift[DATA_BITS-1:1]};
                    if (bit_cnt == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    perr_n  = (((^shift) ^ rxs) != PAR_MODE);
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n  = '0;
                    serr_n = serr | !rxs;
                    if (bit_cnt == LAST_STOP) begin
                        bit_n       = '0;
                        push        = 1'b1;
                        need_high_n = !rxs;
                        state_n     = ST_IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign pop     = data_valid && data_ready;
    assign overrun = push && fifo_full && !pop;

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (baud_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({perr, serr_n, shift}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs are forced to zero while empty so the unreset storage never leaks out.
    assign data_valid   = !fifo_empty;
    assign data_out     = data_valid ? head[DATA_BITS-1:0] : '0;
    assign stop_error   = data_valid && head[DATA_BITS];
    assign parity_error = data_valid && head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default-parameter instance plus a
// 7-bit / no-parity / 2-stop instance, each driven by its own serial line.
module tb_uart_rx_param;

    logic       baud_clk;
    logic       reset;
    logic       rx_a, ready_a;
    logic [7:0] data_a;
    logic       valid_a, perr_a, serr_a, ovr_a;
    logic       rx_b, ready_b;
    logic [6:0] data_b;
    logic       valid_b, perr_b, serr_b, ovr_b;

    int checks;
    int errors;
    int ovr_a_count;
    int ovr_b_count;

    uart_rx_param dut (
        .baud_clk     (baud_clk),
        .reset        (reset),
        .rx_inp       (rx_a),
        .data_out     (data_a),
        .data_valid   (valid_a),
        .data_ready   (ready_a),
        .parity_error (perr_a),
        .stop_error   (serr_a),
        .overrun      (ovr_a)
    );

    uart_rx_param #(
        .DATA_BITS  (7),
        .PARITY_EN  (0),
        .STOP_BITS  (2)
    ) dut7 (
        .baud_clk     (baud_clk),
        .reset        (reset),
        .rx_inp       (rx_b),
        .data_out     (data_b),
        .data_valid   (valid_b),
        .data_ready   (ready_b),
        .parity_error (perr_b),
        .stop_error   (serr_b),
        .overrun      (ovr_b)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(negedge baud_clk) begin
        if (ovr_a) ovr_a_count++;
        if (ovr_b) ovr_b_count++;
    end

    task automatic drive_bit_a(input logic b);
        @(negedge baud_clk);
        rx_a = b;
        repeat (15) @(negedge baud_clk);
    endtask

    task automatic drive_bit_b(input logic b);
        @(negedge baud_clk);
        rx_b = b;
        repeat (15) @(negedge baud_clk);
    endtask

    task automatic send_a(input logic [7:0] d, input logic p);
        drive_bit_a(1'b0);
        for (int i = 0; i < 8; i++) drive_bit_a(d[i]);
        drive_bit_a(p);
        drive_bit_a(1'b1);
    endtask

    task automatic pop_a();
        @(negedge baud_clk);
        ready_a = 1'b1;
        @(negedge baud_clk);
        ready_a = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge baud_clk);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_a); end
        checks++;
        if (data_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_a); end
        checks++;
        if ({perr_a, serr_a, ovr_a} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {perr_a, serr_a, ovr_a}); end
        checks++;
        if ({valid_b, perr_b, serr_b, ovr_b} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_b: got %b expected 0000", {valid_b, perr_b, serr_b, ovr_b}); end
    endtask

    // 0xA5 has four ones, so even parity bit is 0; first sample lands ~171 ticks after the start edge.
    task automatic test_single();
        int n;
        n = 0;
        fork
            send_a(8'hA5, 1'b0);
            begin
                while (!valid_a && n < 300) begin
                    @(posedge baud_clk);
                    #1;
                    n++;
                end
            end
        join
        checks++;
        if (n < 165 || n > 180) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 165..180", n); end
        checks++;
        if (data_a !== 8'hA5) begin errors++; $display("[TB] FAIL single_data: got %h expected a5", data_a); end
        checks++;
        if ({perr_a, serr_a} !== 2'b00) begin errors++; $display("[TB] FAIL single_flags: got %b expected 00", {perr_a, serr_a}); end
        repeat (20) @(negedge baud_clk);
        checks++;
        if ({valid_a, data_a} !== {1'b1, 8'hA5}) begin errors++; $display("[TB] FAIL single_hold: got %b/%h expected 1/a5", valid_a, data_a); end
        pop_a();
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL single_pop: got %b expected 0", valid_a); end
    endtask

    task automatic test_parity();
        send_a(8'h3C, 1'b1);
        checks++;
        if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL parity_valid: got %b expected 1", valid_a); end
        checks++;
        if (data_a !== 8'h3C) begin errors++; $display("[TB] FAIL parity_data: got %h expected 3c", data_a); end
        checks++;
        if ({perr_a, serr_a} !== 2'b10) begin errors++; $display("[TB] FAIL parity_flags: got %b expected 10", {perr_a, serr_a}); end
        pop_a();
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL parity_pop: got %b expected 0", valid_a); end
    endtask

    task automatic test_glitch();
        @(negedge baud_clk);
        rx_a = 1'b0;
        repeat (4) @(negedge baud_clk);
        rx_a = 1'b1;
        repeat (200) @(negedge baud_clk);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL glitch_empty: got %b expected 0", valid_a); end
    endtask

    // Payloads 1..5 with even parity bits 1,1,0,1,0; the fifth frame finds the FIFO full.
    task automatic test_back_to_back();
        logic [7:0] d;
        ovr_a_count = 0;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_a(d, ^d);
            if (i == 4) begin
                checks++;
                if (ovr_a_count !== 0) begin errors++; $display("[TB] FAIL b2b_no_overrun: got %0d expected 0", ovr_a_count); end
            end
        end
        checks++;
        if (ovr_a_count !== 1) begin errors++; $display("[TB] FAIL b2b_overrun: got %0d expected 1", ovr_a_count); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (valid_a !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, valid_a); end
            checks++;
            if (data_a !== 8'(i)) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, data_a, 8'(i)); end
            checks++;
            if ({perr_a, serr_a} !== 2'b00) begin errors++; $display("[TB] FAIL b2b_flags%0d: got %b expected 00", i, {perr_a, serr_a}); end
            pop_a();
        end
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", valid_a); end
    endtask

    task automatic test_seven_bit();
        logic [6:0] d;
        d = 7'h55;
        ovr_b_count = 0;
        drive_bit_b(1'b0);
        for (int i = 0; i < 7; i++) drive_bit_b(d[i]);
        drive_bit_b(1'b1);
        drive_bit_b(1'b0);
        drive_bit_b(1'b1);
        checks++;
        if (valid_b !== 1'b1) begin errors++; $display("[TB] FAIL seven_valid: got %b expected 1", valid_b); end
        checks++;
        if (data_b !== 7'h55) begin errors++; $display("[TB] FAIL seven_data: got %h expected 55", data_b); end
        checks++;
        if ({perr_b, serr_b} !== 2'b01) begin errors++; $display("[TB] FAIL seven_flags: got %b expected 01", {perr_b, serr_b}); end
        checks++;
        if (ovr_b_count !== 0) begin errors++; $display("[TB] FAIL seven_overrun: got %0d expected 0", ovr_b_count); end
    endtask

    // Line held low for 14 bit times: one all-zero framing-error frame, no restart while low.
    task automatic test_break();
        @(negedge baud_clk);
        rx_a = 1'b0;
        repeat (14 * 16) @(negedge baud_clk);
        rx_a = 1'b1;
        repeat (32) @(negedge baud_clk);
        checks++;
        if ({valid_a, data_a} !== {1'b1, 8'h00}) begin errors++; $display("[TB] FAIL break_data: got %b/%h expected 1/00", valid_a, data_a); end
        checks++;
        if ({perr_a, serr_a} !== 2'b01) begin errors++; $display("[TB] FAIL break_flags: got %b expected 01", {perr_a, serr_a}); end
        pop_a();
        repeat (40) @(negedge baud_clk);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL break_single: got %b expected 0", valid_a); end
    endtask

    task automatic test_reset_mid_frame();
        drive_bit_a(1'b0);
        for (int i = 0; i < 3; i++) drive_bit_a(1'b1);
        @(negedge baud_clk);
        reset = 1'b1;
        repeat (2) @(negedge baud_clk);
        reset = 1'b0;
        repeat (20) @(negedge baud_clk);
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_empty: got %b expected 0", valid_a); end
        send_a(8'h12, 1'b0);
        checks++;
        if ({valid_a, data_a} !== {1'b1, 8'h12}) begin errors++; $display("[TB] FAIL midreset_data: got %b/%h expected 1/12", valid_a, data_a); end
        checks++;
        if ({perr_a, serr_a} !== 2'b00) begin errors++; $display("[TB] FAIL midreset_flags: got %b expected 00", {perr_a, serr_a}); end
        pop_a();
        checks++;
        if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pop: got %b expected 0", valid_a); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        ovr_a_count = 0;
        ovr_b_count = 0;
        reset       = 1'b1;
        rx_a        = 1'b1;
        rx_b        = 1'b1;
        ready_a     = 1'b0;
        ready_b     = 1'b0;
        repeat (3) @(negedge baud_clk);
        test_reset();
        reset = 1'b0;
        repeat (5) @(negedge baud_clk);
        $display("[TB] starting directed tests");
        test_single();
        test_parity();
        test_glitch();
        test_back_to_back();
        test_seven_bit();
        test_break();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
